pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards, taken branch/JALR redirects from EX, and JAL in ID.
//  - Holds the pipeline while a MEM-stage data access is pending.
//  - Keeps saturating stall/flush statistics and a sticky memory-timeout flag.
//  - Drives the stage-register enable/clear inputs; sits beside the ID decode path.

---
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, redirects, JAL and MEM-stage waits.
// It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_RUN      | normal flow; a MEM access that is not ready enters S_MEM_WAIT
// S_MEM_WAIT | whole pipe frozen until mem_ready_i; timeout timer running
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             cpu_clk_i,
    input  logic             cpu_rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             id_jal_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_w_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_hold;
    logic               load_use;

    always_comb begin
        mem_hold = (state_q == S_RUN) ? (mem_req_i & ~mem_ready_i) : ~mem_ready_i;
    end

    // x0 is hard-wired zero, so a load into it never creates a dependency
    always_comb begin
        load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                   ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                    (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:      if (mem_hold)    state_d = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_ready_i) state_d = S_RUN;
            default:                     state_d = S_RUN;
        endcase
    end

    // A redirect held behind a MEM wait stays visible on ex_br_taken_i because
    // ID-EX is frozen, so it naturally fires in the release cycle.
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_w_o = 1'b0;
        if (cpu_rst_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
            flush_w_o = 1'b1;
        end else if (mem_hold) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
        end else if (ex_br_taken_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (load_use) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (id_jal_i) begin
            flush_d_o = 1'b1;
        end
    end

    // Timeout timer counts down from MEM_TIMEOUT; the flag fires on the step to zero.
    always_comb begin
        tmr_d         = tmr_q;
        mem_timeout_d = mem_timeout_q;
        if (state_q == S_RUN) begin
            if (state_d == S_MEM_WAIT) begin
                tmr_d = TMR_W'(MEM_TIMEOUT);
            end
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q == TMR_W'(1)) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_d_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            tmr_q         <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            tmr_q         <= tmr_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign mem_timeout_o = mem_timeout_q;

endmodule
